mips_sum_top: RTL and testbench
===============================

// Module: mips_sum_top
// PURPOSE
//   Self-contained single-cycle 32-bit MIPS-subset CPU with a hard-wired program ROM.
//   Reads 4-bit input n through a memory-mapped load and computes sum(1..n).
//   Writes the sum to a 12-bit result register through a memory-mapped store.
//   Top level of the design; the CPU demo/lab target.
// PARAMETERS
//   ROM_WORDS  32      instruction ROM depth (words); unused entries hold 0 (nop)
//   N_ADDR     'h100   byte address of the read-only n port (lw)
//   RES_ADDR   'h104   byte address of the result register (sw)
// PORTS
//   clk     in   1   single system clock, rising edge
//   rst     in   1   synchronous reset, active-low
//   n       in   4   operand; zero-extended to 32 bits on lw from N_ADDR
//   result  out  12  low 12 bits of the last word stored to RES_ADDR
// BEHAVIOUR
//   - Reset (rst==0 at a rising edge): PC=0, result=0, all 32 GPRs=0. $0 is hard-wired to 0.
//   - One instruction per clock. PC, register file and result update on the rising edge.
//   - ISA: addu subu and or slt (R-type); addiu (sign-extended imm); lw sw; beq bne; j.
//     Unknown opcodes execute as nop (PC+4).
//   - Arithmetic is 32-bit with wrap-around and no overflow traps. Branch target = PC+4+(simm<<2).
//   - Memory map: lw N_ADDR -> {28'b0,n}; lw elsewhere -> 0.
//     sw RES_ADDR -> result<=rt[11:0]; sw elsewhere is ignored. No data RAM.
//   - ROM program (byte addr: instr):
//       00 lw $9,0x100($0)    04 addu $8,$0,$0    08 beq $9,$0,+3
//       0C addu $8,$8,$9      10 addiu $9,$9,-1   14 j 0x08
//       18 sw $8,0x104($0)    1C j 0x1C (halt loop)
//   - n is sampled only at cycle 0 after reset release. Later changes to n have no effect until the next reset.
//   - Latency: result becomes valid at rising edge 4n+4 after the first edge with rst==1.
//     Before that edge result holds 0. After it, result holds until reset.
//   - Reset asserted mid-program: restarts from PC=0 and clears result on that edge.
// CONFIGURATION
//   MIPS_HALT_EN defined:
//     - Adds output `done` (1 bit, reset 0).
//     - done is set on the edge where `j` targets its own address.
//     - PC then freezes; done stays 1 until reset.
//   MIPS_HALT_EN undefined:
//     - No done port.
//     - The halt loop simply re-executes `j 0x1C` forever.
//   Result timing is identical either way.
// STRUCTURE
//   - Shared package mips_pkg holds:
//     - opcode/funct constants (OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, F_ADDU...);
//     - ALU-op enum;
//     - N_ADDR/RES_ADDR.
//   - One sub-module mips_regfile: 32x32, 2 async read ports, 1 sync write port, $0 forced to 0.
//   - ROM, decoder, ALU, PC logic and memory map stay inline in mips_sum_top.
// TESTING
//   - n=10, rst low 1 cycle then high -> result=0 until edge 44, then 55 (0x037); stable to end.
//   - n=0 -> result=0 written at edge 4 and stays 0. With MIPS_HALT_EN, done=1 at edge 5.
//   - n=15 -> result=120 at edge 64.
//   - n=10, pulse rst low at edge 20, release -> result stays 0 and becomes 55 at edge 44 after re-release.
//   - n=10, change n to 3 after edge 2 -> result still 55 (n sampled once).
//   - Register check: after completion with n=10, $8=55 and $9=0 via hierarchical peek; $0 always 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, ALU ops and memory map for the sum CPU
package mips_pkg;
    localparam int          ROM_AW    = 5;
    localparam int          ROM_WORDS = 1 << ROM_AW;
    localparam logic [31:0] N_ADDR    = 32'h0000_0100;
    localparam logic [31:0] RES_ADDR  = 32'h0000_0104;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one sync write port, $0 reads 0
module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] regs_q [32];

    // clear every register on reset; writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
endmodule

// File: rtl/mips_sum_top.sv
// mips_sum_top: single-cycle MIPS subset running a fixed sum(1..n) program; MIPS_HALT_EN adds done/PC freeze
module mips_sum_top
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  n,
    output logic [11:0] result
`ifdef MIPS_HALT_EN
    ,
    output logic        done
`endif
);
    logic [31:0]       rom [ROM_WORDS];
    logic [ROM_AW-1:0] rom_idx;
    logic              in_rom;
    logic [31:0]       pc_q, pc_d, next_pc, pc_plus4, br_target, j_target;
    logic [31:0]       instr, imm_sext, rs_val, rt_val, alu_b, alu_y, load_data, wb_data;
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, wa;
    logic [11:0]       result_q, result_d;
    alu_op_e           alu_op;
    logic              src_imm, reg_write, dst_rt, mem_read, mem_write;
    logic              is_beq, is_bne, is_j, take_branch;
    logic [4:0]        unused_shamt;

    // hard-wired program: $8 = sum of $9 counting down from n, then store and spin
    always_comb begin
        for (int i = 0; i < ROM_WORDS; i++) rom[i] = '0;
        rom[0] = 32'h8C09_0100;
        rom[1] = 32'h0000_4021;
        rom[2] = 32'h1120_0003;
        rom[3] = 32'h0109_4021;
        rom[4] = 32'h2529_FFFF;
        rom[5] = 32'h0800_0002;
        rom[6] = 32'hAC08_0104;
        rom[7] = 32'h0800_0007;
    end

    assign rom_idx      = pc_q[ROM_AW+1:2];
    assign in_rom       = pc_q[31:ROM_AW+2] == '0;
    assign instr        = in_rom ? rom[rom_idx] : '0;
    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign unused_shamt = instr[10:6];
    assign funct        = instr[5:0];
    assign imm_sext     = {{16{instr[15]}}, instr[15:0]};

    // decode; anything unrecognised falls through as a nop
    always_comb begin
        alu_op    = ALU_ADD;
        src_imm   = 1'b0;
        reg_write = 1'b0;
        dst_rt    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    F_ADDU:  alu_op = ALU_ADD;
                    F_SUBU:  alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                src_imm   = 1'b1;
                reg_write = 1'b1;
                dst_rt    = 1'b1;
            end
            OP_LW: begin
                src_imm   = 1'b1;
                reg_write = 1'b1;
                dst_rt    = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                src_imm   = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j   = 1'b1;
            default: ;
        endcase
    end

    mips_regfile u_rf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_val),
        .rd2_o (rt_val),
        .we_i  (reg_write),
        .wa_i  (wa),
        .wd_i  (wb_data)
    );

    // ALU, memory map and write-back select
    always_comb begin
        alu_b     = src_imm ? imm_sext : rt_val;
        alu_y     = (alu_op == ALU_SUB) ? rs_val - alu_b :
                    (alu_op == ALU_AND) ? rs_val & alu_b :
                    (alu_op == ALU_OR)  ? rs_val | alu_b :
                    (alu_op == ALU_SLT) ? {31'b0, $signed(rs_val) < $signed(alu_b)} :
                                          rs_val + alu_b;
        load_data = (alu_y == N_ADDR) ? {28'b0, n} : '0;
        wb_data   = mem_read ? load_data : alu_y;
        wa        = dst_rt ? rt : rd;
        result_d  = (mem_write && alu_y == RES_ADDR) ? rt_val[11:0] : result_q;
    end

    // next PC: jump, taken branch, or fall through
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        br_target   = pc_plus4 + {imm_sext[29:0], 2'b00};
        j_target    = {pc_plus4[31:28], instr[25:0], 2'b00};
        take_branch = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
        next_pc     = is_j ? j_target : take_branch ? br_target : pc_plus4;
    end

`ifdef MIPS_HALT_EN
    logic done_q, done_d;

    assign done_d = done_q | (is_j && j_target == pc_q);
    assign pc_d   = done_q ? pc_q : next_pc;
    assign done   = done_q;

    // sticky halt flag, set by a jump to itself
    always_ff @(posedge clk) begin
        if (!rst) done_q <= 1'b0;
        else      done_q <= done_d;
    end
`else
    assign pc_d = next_pc;
`endif

    // architectural state: PC and result register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= '0;
            result_q <= '0;
        end else begin
            pc_q     <= pc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
endmodule

// File: tb/tb_mips_sum_top.sv
// tb_mips_sum_top: directed checks of sum(1..n) result timing, reset behaviour and register state
module tb_mips_sum_top;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  n   = 4'd0;
    logic [11:0] result;
`ifdef MIPS_HALT_EN
    logic        done;
`endif
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    mips_sum_top dut (
        .clk    (clk),
        .rst    (rst),
        .n      (n),
        .result (result)
`ifdef MIPS_HALT_EN
        ,
        .done   (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [3:0] nv);
        n   = nv;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic step_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset(4'd10);
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL reset_result: got %0d expected 0", result);
        end
        checks++;
        if (dut.u_rf.regs_q[8] !== 32'd0) begin
            errors++;
            $display("FAIL reset_r8: got %0h expected 0", dut.u_rf.regs_q[8]);
        end
        checks++;
        if (dut.u_rf.regs_q[9] !== 32'd0) begin
            errors++;
            $display("FAIL reset_r9: got %0h expected 0", dut.u_rf.regs_q[9]);
        end
    endtask

    task automatic test_sum10();
        do_reset(4'd10);
        step_to(43);
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL sum10_edge43: got %0d expected 0", result);
        end
        step_to(44);
        checks++;
        if (result !== 12'h037) begin
            errors++;
            $display("FAIL sum10_edge44: got %0d expected 55", result);
        end
        step_to(70);
        checks++;
        if (result !== 12'h037) begin
            errors++;
            $display("FAIL sum10_stable: got %0d expected 55", result);
        end
        checks++;
        if (dut.u_rf.regs_q[8] !== 32'd55) begin
            errors++;
            $display("FAIL sum10_r8: got %0d expected 55", dut.u_rf.regs_q[8]);
        end
        checks++;
        if (dut.u_rf.regs_q[9] !== 32'd0) begin
            errors++;
            $display("FAIL sum10_r9: got %0d expected 0", dut.u_rf.regs_q[9]);
        end
        checks++;
        if (dut.u_rf.regs_q[0] !== 32'd0) begin
            errors++;
            $display("FAIL sum10_r0: got %0d expected 0", dut.u_rf.regs_q[0]);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL sum10_clear: got %0d expected 0", result);
        end
        rst = 1'b1;
    endtask

    task automatic test_zero();
        do_reset(4'd0);
        step_to(3);
`ifdef MIPS_HALT_EN
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_early: got %0b expected 0", done);
        end
`endif
        step_to(4);
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL zero_edge4: got %0d expected 0", result);
        end
        checks++;
        if (dut.pc_q !== 32'h1C) begin
            errors++;
            $display("FAIL zero_pc: got %0h expected 1c", dut.pc_q);
        end
        step_to(5);
`ifdef MIPS_HALT_EN
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero_done_edge5: got %0b expected 1", done);
        end
`endif
        step_to(12);
        checks++;
        if (result !== 12'd0 || dut.pc_q !== 32'h1C) begin
            errors++;
            $display("FAIL zero_halt: got result=%0d pc=%0h expected 0/1c", result, dut.pc_q);
        end
    endtask

    task automatic test_n15();
        do_reset(4'd15);
        step_to(63);
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL n15_edge63: got %0d expected 0", result);
        end
        step_to(64);
        checks++;
        if (result !== 12'd120) begin
            errors++;
            $display("FAIL n15_edge64: got %0d expected 120", result);
        end
    endtask

    task automatic test_small();
        do_reset(4'd1);
        step_to(7);
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL n1_edge7: got %0d expected 0", result);
        end
        step_to(8);
        checks++;
        if (result !== 12'd1) begin
            errors++;
            $display("FAIL n1_edge8: got %0d expected 1", result);
        end
        do_reset(4'd5);
        step_to(24);
        checks++;
        if (result !== 12'd15) begin
            errors++;
            $display("FAIL n5_edge24: got %0d expected 15", result);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(4'd10);
        step_to(20);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 12'd0 || dut.pc_q !== 32'd0) begin
            errors++;
            $display("FAIL midrst_edge: got result=%0d pc=%0h expected 0/0", result, dut.pc_q);
        end
        rst = 1'b1;
        cyc = 0;
        step_to(43);
        checks++;
        if (result !== 12'd0) begin
            errors++;
            $display("FAIL midrst_edge43: got %0d expected 0", result);
        end
        step_to(44);
        checks++;
        if (result !== 12'd55) begin
            errors++;
            $display("FAIL midrst_edge44: got %0d expected 55", result);
        end
    endtask

    task automatic test_n_change();
        do_reset(4'd10);
        step_to(2);
        n = 4'd3;
        step_to(44);
        checks++;
        if (result !== 12'd55) begin
            errors++;
            $display("FAIL nchange_edge44: got %0d expected 55", result);
        end
    endtask

    initial begin
        test_reset();
        test_sum10();
        test_zero();
        test_n15();
        test_small();
        test_mid_reset();
        test_n_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
